// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file writeback unit.
// An entry is one pending mul/div result: destination register plus data.
package wb_pkg;
    localparam int REG_AW  = 5;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = REG_AW + DATA_W;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MD   = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small result FIFO for mul/div results; the head entry is readable without a pop.
// Callers never push when full or pop when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    wb_entry_t         mem [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Owns the register file write port: merges ALU results with queued mul/div
// results, bounds mul/div starvation, and tracks outstanding mul/div destinations.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_d,
    output logic              alu_stall,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_a,
    input  logic [DATA_W-1:0] md_d,
    input  logic              busy_set,
    input  logic [REG_AW-1:0] busy_a,
    output logic [31:0]       busy,
    output logic              we3,
    output logic [REG_AW-1:0] a3,
    output logic [DATA_W-1:0] wd3
);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] SC_MAX = SCW'(STARVE_LIMIT);

    // Handshakes: a mul/div result transfers on any cycle with md_valid && md_ready
    // (r0 results transfer and are dropped); an ALU result is consumed on any cycle
    // with alu_valid && !alu_stall, otherwise the producer holds it unchanged.

    wb_src_t           src;
    wb_entry_t         head;
    wb_entry_t         md_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              md_push;
    logic              md_pop;
    logic [SCW-1:0]    sc;
    logic [REG_AW-1:0] sel_a;
    logic [DATA_W-1:0] sel_d;
    logic [31:0]       busy_next;

    assign md_ready = !fifo_full;
    assign md_push  = md_valid && md_ready && (md_a != '0);
    assign md_entry = '{addr: md_a, data: md_d};
    assign md_pop   = (src == SRC_MD);

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (md_push),
        .pop   (md_pop),
        .din   (md_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration uses only registered state and alu_valid, never md_valid.
    always_comb begin
        src       = SRC_NONE;
        alu_stall = 1'b0;
        if (!fifo_empty && (sc == SC_MAX)) begin
            src       = SRC_MD;
            alu_stall = alu_valid;
        end else if (alu_valid) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_MD;
        end
    end

    always_comb begin
        sel_a = alu_a;
        sel_d = alu_d;
        if (src == SRC_MD) begin
            sel_a = head.addr;
            sel_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc <= '0;
        end else if (md_pop || fifo_empty) begin
            sc <= '0;
        end else if ((src == SRC_ALU) && (sc != SC_MAX)) begin
            sc <= sc + SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (src != SRC_NONE) begin
            we3 <= (sel_a != '0);
            a3  <= sel_a;
            wd3 <= sel_d;
        end else begin
            we3 <= 1'b0;
        end
    end

    // A new dispatch to the register being retired this cycle must stay busy.
    always_comb begin
        busy_next = busy;
        if (md_pop) begin
            busy_next[head.addr] = 1'b0;
        end
        if (busy_set && (busy_a != '0)) begin
            busy_next[busy_a] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
endmodule
